// File: rtl/term_fifo_pkg.sv
// term_fifo_pkg
//   Shared definitions for the multi-channel terminal buffer:
//   - width helpers for the per-channel occupancy count and pointers
//   - rr_next(): round-robin search for the first non-empty channel
//   Channel vectors are zero-extended to MAX_CH bits before being
//   handed to rr_next(), so a bank may hold at most MAX_CH channels.
package term_fifo_pkg;

  localparam int MAX_CH    = 32;
  localparam int IDX_W     = $clog2(MAX_CH);
  localparam int DEF_DEPTH = 4;
  localparam int CNT_W_DEF = $clog2(DEF_DEPTH + 1);
  localparam int PTR_W_DEF = $clog2(DEF_DEPTH);

  // Count must be able to hold the value depth itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Returns {found, idx}: first set bit of nonempty_vec at or after
  // start, wrapping modulo n. idx is start when nothing is found.
  function automatic logic [IDX_W:0] rr_next(input logic [IDX_W-1:0] start,
                                             input logic [MAX_CH-1:0] nonempty_vec,
                                             input int n);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;
    found = 1'b0;
    idx   = start;
    for (int i = 0; i < MAX_CH; i++) begin
      j = int'(start) + i;
      if (j >= n) j = j - n;
      if ((i < n) && !found && nonempty_vec[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/term_fifo.sv
// term_fifo
//   One circular packet FIFO channel.
//   Ports:
//     clk, reset    clock / asynchronous active-high reset (control only)
//     push, din     write strobe and packet
//     pop           dequeue request (ignored when empty)
//     head          packet at the read pointer
//     full          registered, occupancy == fifo_depth
//     empty         occupancy == 0
//     count_next    occupancy after the coming edge
//   A push on a full channel is accepted only when a pop on the same
//   edge frees the slot; otherwise it is dropped here and reported by
//   the bank.
module term_fifo
  import term_fifo_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  localparam int CNT_W     = cnt_width(fifo_depth),
  localparam int PTR_W     = ptr_width(fifo_depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] din,
  input  logic               pop,
  output logic [pckg_sz-1:0] head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count_next
);

  logic [pckg_sz-1:0] mem_q [fifo_depth];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               do_push, do_pop, at_cap;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    at_cap   = (count_q == CNT_W'(fifo_depth));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!at_cap || do_pop);
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    full_d   = (count_d == CNT_W'(fifo_depth));
  end

  // Control state: pointers, occupancy, full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Packet storage
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head       = mem_q[rd_ptr_q];
  assign full       = full_q;
  assign empty      = (count_q == '0);
  assign count_next = count_d;

endmodule

// File: rtl/term_fifo_bank.sv
// term_fifo_bank
//   num_ch packet FIFOs feeding one consumer through a pending/pop
//   handshake, with a round-robin arbiter choosing the channel.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     push        per-channel write strobe
//     data_in     per-channel packet (channel c in data_in[c])
//     full        per-channel registered full flag
//     pop         consumer accepts the presented packet
//     pndng       a packet is presented on data_out
//     data_out    head packet of the granted channel (0 during reset)
//     ch_id       granted channel index
//     overflow    sticky, per channel: push dropped on a full channel
//     underflow   sticky: pop seen while nothing was pending
//   The arbiter searches on post-edge occupancies, so a pop is followed
//   by the next packet with no bubble, and a grant held without pop is
//   never preempted by pushes to other channels.
module term_fifo_bank
  import term_fifo_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int num_ch     = 4,
  localparam int CW        = $clog2(num_ch)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [num_ch-1:0]              push,
  input  logic [num_ch-1:0][pckg_sz-1:0] data_in,
  output logic [num_ch-1:0]              full,
  input  logic                           pop,
  output logic                           pndng,
  output logic [pckg_sz-1:0]             data_out,
  output logic [CW-1:0]                  ch_id,
  output logic [num_ch-1:0]              overflow,
  output logic                           underflow
);

  localparam int CNT_W = cnt_width(fifo_depth);

  logic [pckg_sz-1:0] head_w  [num_ch];
  logic [CNT_W-1:0]   cnt_nxt [num_ch];
  logic [num_ch-1:0]  full_w, empty_w, pop_ch, nonempty_nxt;

  logic [CW-1:0]      cur_q, cur_d, start;
  logic               pndng_q, pndng_d, search;
  logic [num_ch-1:0]  ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [IDX_W:0]     rr;

  for (genvar c = 0; c < num_ch; c++) begin : g_ch
    assign pop_ch[c]       = pop && pndng_q && (cur_q == CW'(c)) && !empty_w[c];
    assign nonempty_nxt[c] = (cnt_nxt[c] != '0);

    term_fifo #(
      .pckg_sz   (pckg_sz),
      .fifo_depth(fifo_depth)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[c]),
      .din       (data_in[c]),
      .pop       (pop_ch[c]),
      .head      (head_w[c]),
      .full      (full_w[c]),
      .empty     (empty_w[c]),
      .count_next(cnt_nxt[c])
    );
  end

  always_comb begin
    cur_d   = cur_q;
    pndng_d = pndng_q;
    start   = cur_q;
    search  = 1'b0;
    if (pop && pndng_q) begin
      // The granted channel has been served: continue after it.
      search = 1'b1;
      start  = (cur_q == CW'(num_ch - 1)) ? '0 : cur_q + 1'b1;
    end else if (!pndng_q) begin
      search = 1'b1;
    end
    rr = rr_next(IDX_W'(start), MAX_CH'(nonempty_nxt), num_ch);
    if (search) begin
      if (rr[IDX_W]) begin
        cur_d   = CW'(rr[IDX_W-1:0]);
        pndng_d = 1'b1;
      end else begin
        pndng_d = 1'b0;
      end
    end
    ovf_d = ovf_q | (push & full_w & ~pop_ch);
    unf_d = unf_q | (pop & ~pndng_q);
  end

  // Arbiter and sticky status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      pndng_q <= 1'b0;
      ovf_q   <= '0;
      unf_q   <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      pndng_q <= pndng_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pndng     = pndng_q;
  assign ch_id     = cur_q;
  assign data_out  = reset ? '0 : head_w[cur_q];
  assign full      = full_w;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_term_fifo_bank.sv
module tb_term_fifo_bank;

  localparam int PW = 40;
  localparam int NC = 4;

  logic                   clk;
  logic                   reset;
  logic [NC-1:0]          push;
  logic [NC-1:0][PW-1:0]  data_in;
  logic [NC-1:0]          full;
  logic                   pop;
  logic                   pndng;
  logic [PW-1:0]          data_out;
  logic [1:0]             ch_id;
  logic [NC-1:0]          overflow;
  logic                   underflow;

  int n_total = 0;
  int n_pass  = 0;

  term_fifo_bank #(
    .pckg_sz   (PW),
    .fifo_depth(4),
    .num_ch    (NC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .data_in  (data_in),
    .full     (full),
    .pop      (pop),
    .pndng    (pndng),
    .data_out (data_out),
    .ch_id    (ch_id),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic p, input logic [1:0] id,
                           input logic [PW-1:0] d);
    check({tag, ".pndng"}, 64'(pndng), 64'(p));
    if (p) begin
      check({tag, ".ch_id"}, 64'(ch_id), 64'(id));
      check({tag, ".data"}, 64'(data_out), 64'(d));
    end
  endtask

  initial begin
    reset   = 1'b1;
    push    = '0;
    pop     = 1'b0;
    data_in = '0;

    // Reset state
    tick();
    tick();
    check("rst.pndng", 64'(pndng), 64'd0);
    check("rst.ch_id", 64'(ch_id), 64'd0);
    check("rst.full", 64'(full), 64'd0);
    check("rst.ovf", 64'(overflow), 64'd0);
    check("rst.unf", 64'(underflow), 64'd0);
    check("rst.data", 64'(data_out), 64'd0);
    reset = 1'b0;

    // Single push on ch2, then asynchronous reset mid-cycle
    data_in[2] = 40'hA5;
    push = 4'b0100;
    tick();
    push = '0;
    check_out("t1", 1'b1, 2'd2, 40'hA5);
    #2;
    reset = 1'b1;
    #1;
    check("t1.async_pndng", 64'(pndng), 64'd0);
    check("t1.async_ch", 64'(ch_id), 64'd0);
    check("t1.async_data", 64'(data_out), 64'd0);
    tick();
    #2;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1.post_rst_pndng", 64'(pndng), 64'd0);
    end

    // Fill ch0, overflow, ordered drain
    for (int v = 1; v <= 4; v++) begin
      data_in[0] = PW'(v);
      push = 4'b0001;
      tick();
      if (v == 1) check_out("t2.first", 1'b1, 2'd0, 40'd1);
    end
    check("t2.full4", 64'(full), 64'b0001);
    check("t2.ovf_before", 64'(overflow), 64'd0);
    data_in[0] = 40'd5;
    tick();
    push = '0;
    check("t2.full5", 64'(full), 64'b0001);
    check("t2.ovf", 64'(overflow), 64'b0001);
    pop = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      check_out("t2.drain", 1'b1, 2'd0, PW'(v));
      tick();
    end
    pop = 1'b0;
    check("t2.empty_pndng", 64'(pndng), 64'd0);
    check("t2.full_clr", 64'(full), 64'd0);

    // One packet per channel, pop every cycle: no bubbles
    for (int c = 0; c < NC; c++) data_in[c] = PW'(10 + c);
    push = 4'b1111;
    tick();
    push = '0;
    check_out("t3.c0", 1'b1, 2'd0, 40'd10);
    pop = 1'b1;
    for (int c = 1; c < NC; c++) begin
      tick();
      check_out("t3.rr", 1'b1, 2'(c), PW'(10 + c));
    end
    tick();
    pop = 1'b0;
    check("t3.done", 64'(pndng), 64'd0);

    // Grant held on ch1 while ch0 is pushed; then ch2, then ch0
    data_in[1] = 40'h21;
    data_in[2] = 40'h22;
    push = 4'b0110;
    tick();
    push = '0;
    check_out("t4.grant1", 1'b1, 2'd1, 40'h21);
    data_in[0] = 40'h20;
    push = 4'b0001;
    tick();
    push = '0;
    check_out("t4.hold_a", 1'b1, 2'd1, 40'h21);
    tick();
    tick();
    check_out("t4.hold_b", 1'b1, 2'd1, 40'h21);
    pop = 1'b1;
    tick();
    check_out("t4.next2", 1'b1, 2'd2, 40'h22);
    tick();
    check_out("t4.next0", 1'b1, 2'd0, 40'h20);
    tick();
    pop = 1'b0;
    check("t4.done", 64'(pndng), 64'd0);

    // Pop with nothing pending
    check("t5.unf_before", 64'(underflow), 64'd0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t5.unf", 64'(underflow), 64'd1);
    check("t5.pndng", 64'(pndng), 64'd0);
    check("t5.full", 64'(full), 64'd0);
    data_in[1] = 40'h31;
    push = 4'b0010;
    tick();
    push = '0;
    check_out("t5.after", 1'b1, 2'd1, 40'h31);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t5.drained", 64'(pndng), 64'd0);

    // ch3 full: simultaneous push and pop
    for (int v = 0; v < 4; v++) begin
      data_in[3] = PW'(8'h71 + v);
      push = 4'b1000;
      tick();
      if (v == 0) check_out("t6.first", 1'b1, 2'd3, 40'h71);
    end
    push = '0;
    check("t6.full", 64'(full), 64'b1000);
    data_in[3] = 40'h77;
    push = 4'b1000;
    pop  = 1'b1;
    tick();
    push = '0;
    pop  = 1'b0;
    check_out("t6.swap", 1'b1, 2'd3, 40'h72);
    check("t6.full_kept", 64'(full), 64'b1000);
    check("t6.ovf", 64'(overflow), 64'b0001);
    pop = 1'b1;
    tick();
    check_out("t6.d73", 1'b1, 2'd3, 40'h73);
    tick();
    check_out("t6.d74", 1'b1, 2'd3, 40'h74);
    tick();
    check_out("t6.d77", 1'b1, 2'd3, 40'h77);
    tick();
    pop = 1'b0;
    check("t6.done", 64'(pndng), 64'd0);

    // Pop of the last packet together with a push
    data_in[0] = 40'h55;
    push = 4'b0001;
    tick();
    push = '0;
    check_out("t7.first", 1'b1, 2'd0, 40'h55);
    data_in[0] = 40'h56;
    push = 4'b0001;
    pop  = 1'b1;
    tick();
    push = '0;
    check_out("t7.refill", 1'b1, 2'd0, 40'h56);
    tick();
    pop = 1'b0;
    check("t7.done", 64'(pndng), 64'd0);
    check("t7.unf_sticky", 64'(underflow), 64'd1);
    check("t7.ovf_sticky", 64'(overflow), 64'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/term_fifo_bank.md
# term_fifo_bank

Multi-channel terminal buffer for the mesh network. It holds up to `num_ch` independent packet FIFOs and presents one packet at a time to a single consumer through the mesh pending/pop handshake. A round-robin arbiter picks the channel. It extends the single-FIFO terminal port with configurable channel count, overflow/underflow reporting and bubble-free arbitration. It sits between the per-source push ports and one router input link.

## Interface
Parameters:
- `pckg_sz`, 40, packet width in bits
- `fifo_depth`, 4, entries per channel FIFO; must be ≥ 2
- `num_ch`, 4, number of input channels; must be ≥ 2. `CW = $clog2(num_ch)`

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `push`  in  num_ch  per-channel write strobe
- `data_in`  in  num_ch×pckg_sz  per-channel packet
- `full`  out  num_ch  channel occupancy == fifo_depth
- `pop`  in  1  consumer accepts the presented packet
- `pndng`  out  1  a packet is presented on `data_out`
- `data_out`  out  pckg_sz  head packet of the granted channel
- `ch_id`  out  CW  index of the granted channel
- `overflow`  out  num_ch  sticky: push was dropped on a full channel
- `underflow`  out  1  sticky: `pop` was seen while `pndng` was 0

## Operation
- Each channel is a circular FIFO with a read pointer, a write pointer and an occupancy count of `$clog2(fifo_depth+1)` bits. Pointers wrap modulo `fifo_depth`.
- Push on a non-full channel writes `data_in[c]` and increments the count.
- Push on a full channel:
  - with no pop on that channel in the same cycle: data dropped, count unchanged, `overflow[c]` set.
  - with a pop on that channel in the same cycle: accepted, count unchanged, no overflow.
- Push and pop on a channel that is neither empty nor full: both performed, count unchanged.
- The arbiter holds registers `cur` (CW bits) and `pndng`.
- Arbitration runs on each edge in two cases, and uses post-edge occupancies (after this edge's pushes and pops):
  - If `pop && pndng`: dequeue channel `cur`, then search for the first non-empty channel starting at `cur+1` and wrapping through `cur`.
  - Else if `!pndng`: search starting at `cur`.
  - If a non-empty channel is found, load its index into `cur` and set `pndng=1`. Otherwise set `pndng=0` and leave `cur` unchanged.
- While `pndng=1` and `pop=0`, `cur`, `ch_id` and `data_out` are frozen. Pushes to other channels do not preempt the grant.
- `data_out` = head entry of channel `cur`, read combinationally from registered state. `ch_id = cur`.
- `pop` while `pndng=0`: ignored, `underflow` set.
- Overflow and underflow flags clear only on reset.

## Timing
- Reset values: `pndng=0`, `cur=0`, `ch_id=0`, `full=0`, `overflow=0`, `underflow=0`. All counts and pointers are 0. `data_out` is don't-care; it is driven to 0 while in reset.
- Reset asserted mid-operation: `pndng` drops the same instant, with no clock edge needed. Stored packets are discarded.
- Push into an empty bank at edge k: `pndng=1` in the cycle after edge k (latency 1 edge).
- Pop at edge k with another packet queued in any channel: the next packet is presented after edge k, with no bubble cycle.
- Pop of the last packet together with a push at the same edge: `pndng` stays 1 and the pushed packet is presented.
- `full[c]` is registered and updates the cycle after the edge that changed the count.

## Structure
- Package `term_fifo_pkg`:
  - function `rr_next(start, nonempty_vec)` returning {found, idx}.
  - localparams for count and pointer widths.
- Sub-module `term_fifo` (`pckg_sz`, `fifo_depth`):
  - ports: `clk`, `reset`, `push`, `din`, `pop`, `head`, `full`, `empty`, `count_next`.
  - instantiated `num_ch` times.
- Arbiter, sticky flags and output mux live in the top level.

## Test plan
- Reset, then push 0xA5 on ch2 → `pndng=1`, `ch_id=2`, `data_out=0xA5` one cycle later. Assert `reset` mid-cycle → `pndng=0` immediately, and stays 0 for at least 4 cycles after release with no pushes.
- Fill ch0 with 4 packets 1..4, push a 5th → `full[0]=1`, `overflow[0]=1`. Pops return 1,2,3,4 in order. `pndng` drops after the 4th pop.
- Push one packet on every channel (ch0=10, ch1=11, ch2=12, ch3=13) in the same cycle, pop every cycle → `ch_id` sequence 0,1,2,3 with `pndng` continuously 1. No bubbles.
- Hold `pop=0` while granted to ch1, then push on ch0 → `ch_id` stays 1 and `data_out` stays stable until the pop. The next grant is ch2 if it is non-empty, otherwise ch0.
- Pop with `pndng=0` → `underflow=1`, all counts unchanged.
- ch3 full: push 0x77 and pop the ch3 head in the same cycle → count stays 4, `overflow[3]=0`, and 0x77 is returned last.
